// File: rtl/finalsoc_gpio_pkg.sv
// rtl/finalsoc_gpio_pkg.sv - shared register map and edge-mode codes for the GPIO capture block
package finalsoc_gpio_pkg;

    // Avalon slave register map
    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,   // synchronized input levels (read-only)
        ADDR_DIR  = 2'd1,   // reserved, reads zero, writes ignored
        ADDR_MASK = 2'd2,   // interrupt mask
        ADDR_EDGE = 2'd3    // edge capture, write-1-to-clear
    } gpio_addr_e;

    // Capture mode selection
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int MAX_WIDTH       = 32;
    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

endpackage

// File: rtl/finalsoc_gpio_sync.sv
// rtl/finalsoc_gpio_sync.sv - multi-stage synchronizer for asynchronous inputs
//   clk   : sampling clock
//   reset : synchronous active-high clear of every stage
//   d     : asynchronous input vector
//   q     : synchronized output, SYNC_STAGES-1 edges behind the first sample
module finalsoc_gpio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/finalsoc_gpio_capture.sv
// rtl/finalsoc_gpio_capture.sv - GPIO input edge capture with Avalon register slave and level irq
//   clk, reset         : single clock, synchronous active-high reset
//   address            : register select (data / reserved / mask / edge capture)
//   chipselect, write_n: write qualifiers (write when chipselect=1 and write_n=0)
//   writedata          : write data, bits [WIDTH-1:0] used
//   in_port            : asynchronous external inputs
//   readdata           : registered read data, one cycle after address
//   irq                : level interrupt, |(edgecapture & irqmask)
module finalsoc_gpio_capture
    import finalsoc_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("finalsoc_gpio_capture: WIDTH must be 1..32");
        end
        if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
            $error("finalsoc_gpio_capture: SYNC_STAGES must be 2..4");
        end
        if (EDGE_TYPE != EDGE_RISE && EDGE_TYPE != EDGE_FALL && EDGE_TYPE != EDGE_ANY) begin : g_bad_edge
            $error("finalsoc_gpio_capture: EDGE_TYPE must be 0, 1 or 2");
        end
    endgenerate

    // Detection stays disabled until both data_sync and prev hold samples
    // taken after reset release. The first valid synchronized level is the
    // baseline, so an input held high through reset never looks like an edge.
    localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] data_sync;
    logic [WIDTH-1:0] prev_q,     prev_d;
    logic [WIDTH-1:0] edgecap_q,  edgecap_d;
    logic [WIDTH-1:0] irqmask_q,  irqmask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [2:0]       warm_q,     warm_d;

    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic             wdata_unused;

    assign wdata        = writedata[WIDTH-1:0];
    assign wdata_unused = &{1'b0, writedata};

    finalsoc_gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (data_sync)
    );

    always_comb begin
        edge_raw = '0;
        if (EDGE_TYPE == EDGE_RISE) begin
            edge_raw = data_sync & ~prev_q;
        end else if (EDGE_TYPE == EDGE_FALL) begin
            edge_raw = ~data_sync & prev_q;
        end else begin
            edge_raw = data_sync ^ prev_q;
        end
        edge_det = (warm_q == WARM_LAST) ? edge_raw : '0;
    end

    always_comb begin
        wr_en     = chipselect & ~write_n;
        clr_bits  = (wr_en && address == ADDR_EDGE) ? wdata : '0;
        irqmask_d = (wr_en && address == ADDR_MASK) ? wdata : irqmask_q;
        // Set wins over a coincident write-1-to-clear.
        edgecap_d = (edgecap_q & ~clr_bits) | edge_det;
        prev_d    = data_sync;
        warm_d    = (warm_q == WARM_LAST) ? warm_q : warm_q + 3'd1;

        // Reads see register state before this edge, so a write is visible
        // to a read of the same address issued in the following cycle.
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d = 32'(data_sync);
            ADDR_MASK: readdata_d = 32'(irqmask_q);
            ADDR_EDGE: readdata_d = 32'(edgecap_q);
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            readdata_q <= '0;
            warm_q     <= '0;
        end else begin
            prev_q     <= prev_d;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
            warm_q     <= warm_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_finalsoc_gpio_capture.sv
// tb/tb_finalsoc_gpio_capture.sv - self-checking bench for finalsoc_gpio_capture in all three edge modes
module tb_finalsoc_gpio_capture;

    localparam int W = 8;
    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] rd_a  [3];
    logic        irq_a [3];

    always #5 clk = ~clk;

    finalsoc_gpio_capture #(.WIDTH(W), .SYNC_STAGES(N), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a[0]), .irq(irq_a[0]));
    finalsoc_gpio_capture #(.WIDTH(W), .SYNC_STAGES(N), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a[1]), .irq(irq_a[1]));
    finalsoc_gpio_capture #(.WIDTH(W), .SYNC_STAGES(N), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a[2]), .irq(irq_a[2]));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: input samples taken since reset release; the
    // synchronized level is the sample from N-1 edges ago, the previous level
    // one edge older, and detection requires both to be post-reset samples.
    logic [W-1:0] samp[$];
    logic [W-1:0] m_cap [3];
    logic [W-1:0] m_mask;
    logic [31:0]  m_rd  [3];

    task automatic model_edge();
        logic [W-1:0] ds, pv, det, clr;
        int n;
        if (reset) begin
            samp.delete();
            m_mask = '0;
            for (int m = 0; m < 3; m++) begin
                m_cap[m] = '0;
                m_rd[m]  = '0;
            end
        end else begin
            n   = samp.size();
            ds  = (n >= N)     ? samp[n-N]   : '0;
            pv  = (n >= N + 1) ? samp[n-N-1] : '0;
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            for (int m = 0; m < 3; m++) begin
                case (m)
                    0:       det = ds & ~pv;
                    1:       det = ~ds & pv;
                    default: det = ds ^ pv;
                endcase
                if (n < N + 1) det = '0;
                case (address)
                    2'd0:    m_rd[m] = {24'h0, ds};
                    2'd2:    m_rd[m] = {24'h0, m_mask};
                    2'd3:    m_rd[m] = {24'h0, m_cap[m]};
                    default: m_rd[m] = 32'h0;
                endcase
                m_cap[m] = (m_cap[m] & ~clr) | det;
            end
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            samp.push_back(in_port);
            if (samp.size() > N + 1) void'(samp.pop_front());
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("readdata_m%0d", m), rd_a[m], m_rd[m]);
            chk($sformatf("irq_m%0d", m), {31'h0, irq_a[m]}, {31'h0, |(m_cap[m] & m_mask)});
        end
    endtask

    task automatic step(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        step(3);
        chk("reset_readdata", rd_a[0], 32'h0);
        chk("reset_irq", {31'h0, irq_a[0]}, 32'h0);

        // Data read of a held pattern
        reset   = 1'b0;
        in_port = 8'hA5;
        step(4);
        chk("data_a5", rd_a[0], 32'h0000_00A5);

        // Rising capture on bit0 with mask bit0, then clear
        wr(2'd2, 32'h1);
        in_port = 8'hA4;
        step(4);
        in_port = 8'hA5;
        step(4);
        chk("irq_rise", {31'h0, irq_a[0]}, 32'h1);
        address = 2'd3;
        step(2);
        chk("edgecap_rise", rd_a[0], 32'h1);
        wr(2'd3, 32'h1);
        chk("irq_after_clear", {31'h0, irq_a[0]}, 32'h0);
        step(2);

        // Clears issued every cycle while bit0 toggles: sets must win
        for (int i = 0; i < 8; i++) begin
            in_port[0] = ~in_port[0];
            wr(2'd3, 32'h1);
        end
        chk("collision_any", {31'h0, irq_a[2]}, 32'h1);
        step(4);

        // Masking: all bits captured with mask 0, then unmask bit7
        wr(2'd2, 32'h0);
        wr(2'd3, 32'hFF);
        in_port = 8'h00;
        step(4);
        in_port = 8'hFF;
        step(4);
        chk("masked_irq", {31'h0, irq_a[0]}, 32'h0);
        wr(2'd2, 32'h80);
        chk("unmask_irq", {31'h0, irq_a[0]}, 32'h1);

        // Any-edge pulse on bit3
        wr(2'd3, 32'hFF);
        step(3);
        in_port = 8'hF7;
        step(3);
        in_port = 8'hFF;
        step(3);
        address = 2'd3;
        step(2);
        chk("any_bit3", rd_a[2] & 32'h8, 32'h8);

        // Input held high through reset: no spurious capture
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(8);
        chk("no_spurious_rise", rd_a[0], 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            writedata  = $urandom;
            if ($urandom_range(0, 2) == 0) in_port = 8'($urandom);
            step(1);
        end
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
